// File: rtl/gate_test_sequencer.sv
// Stimulus/monitor sequencer for a single-input gate under test.
// Walks a loaded bit pattern onto dut_in, waits SETTLE_CYCLES, samples
// dut_out against the expected value and keeps a saturating mismatch count.
//
// Handshake: start is a request that is taken only while the sequencer is
// idle (busy=0 and not in the DONE cycle); abort cancels any active run and
// also drops a start presented in the same idle cycle. done pulses once per
// completed run, with pass/err_count/first_err_idx valid from then on.
module gate_test_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter bit INVERT        = 1'b1,
    parameter int ERR_W         = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      pattern,
    input  logic [4:0]       len,
    input  logic             dut_out,
    output logic             dut_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       first_err_idx,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    // Settle counter counts SETTLE_CYCLES-1 down to 0.
    localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic [15:0]      pat_q, pat_d;
    logic [4:0]       len_q, len_d;
    logic             dut_in_q, dut_in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       first_q, first_d;

    logic             last_vec;
    logic             mismatch;

    assign last_vec = ({1'b0, idx_q} == (len_q - 5'd1));
    assign mismatch = (dut_out != (pat_q[idx_q] ^ INVERT));

    // State and datapath registers; reset has priority over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            pat_q    <= '0;
            len_q    <= '0;
            dut_in_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            first_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            dut_in_q <= dut_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            first_q  <= first_d;
        end
    end

    // Next-state logic; abort beats start and forces IDLE from anywhere.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (start) state_d = (len == 5'd0) ? S_DONE : S_DRIVE;
                S_DRIVE:  state_d = S_SETTLE;
                S_SETTLE: if (cnt_q == '0) state_d = S_SAMPLE;
                S_SAMPLE: state_d = last_vec ? S_DONE : S_DRIVE;
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Output and datapath next values, all registered.
    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        pat_d    = pat_q;
        len_d    = len_q;
        dut_in_d = dut_in_q;
        err_d    = err_q;
        first_d  = first_q;
        pass_d   = pass_q;

        if (abort) begin
            if (state_q != S_IDLE) begin
                dut_in_d = 1'b0;
                idx_d    = '0;
                err_d    = '0;
                first_d  = '0;
                pass_d   = 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pat_d   = pattern;
                        len_d   = (len > 5'd16) ? 5'd16 : len;
                        idx_d   = '0;
                        err_d   = '0;
                        first_d = '0;
                        pass_d  = 1'b0;
                    end
                end
                S_DRIVE: begin
                    dut_in_d = pat_q[idx_q];
                    cnt_d    = CNT_LOAD;
                end
                S_SETTLE: begin
                    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                end
                S_SAMPLE: begin
                    if (mismatch) begin
                        if (err_q != ERR_MAX) err_d = err_q + 1'b1;
                        // The counter never returns to zero mid-run, so zero means no earlier mismatch.
                        if (err_q == '0) first_d = idx_q;
                    end
                    if (!last_vec) idx_d = idx_q + 4'd1;
                end
                S_DONE: begin
                    dut_in_d = 1'b0;
                    idx_d    = '0;
                end
                default: begin
                    dut_in_d = 1'b0;
                end
            endcase
        end

        // Verdict is taken on entry to DONE so it includes the final sample.
        if (state_d == S_DONE) pass_d = (err_d == '0);
    end

    assign busy_d = (state_d == S_DRIVE) || (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    assign done_d = (state_d == S_DONE);

    assign dut_in        = dut_in_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: a modelled gate drives dut_out, and every
// run is predicted from the pattern, length and gate behaviour.
module tb_gate_test_sequencer;

    localparam int S = 2;

    // Gate behaviours: 0 inverter, 1 stuck at 0, 2 stuck at 1, 3 buffer.
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] pattern = '0;
    logic [4:0]  len = '0;
    logic        dut_out;
    logic        dut_in, busy, done, pass;
    logic [4:0]  err_count;
    logic [3:0]  first_err_idx;
    logic [2:0]  dbg_state;
    int          gate_mode = 0;

    // Second instance with a 2-bit error counter for saturation.
    logic        start_s = 1'b0;
    logic        abort_s = 1'b0;
    logic [15:0] pattern_s = '0;
    logic [4:0]  len_s = '0;
    logic        dut_out_s = 1'b0;
    logic        dut_in_s, busy_s, done_s, pass_s;
    logic [1:0]  err_s;
    logic [3:0]  first_s;
    logic [2:0]  dbg_s;

    int n_cmp = 0;
    int n_fail = 0;

    gate_test_sequencer #(.SETTLE_CYCLES(S), .INVERT(1'b1), .ERR_W(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pattern(pattern), .len(len), .dut_out(dut_out), .dut_in(dut_in),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_idx(first_err_idx), .dbg_state(dbg_state)
    );

    gate_test_sequencer #(.SETTLE_CYCLES(S), .INVERT(1'b1), .ERR_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s),
        .pattern(pattern_s), .len(len_s), .dut_out(dut_out_s), .dut_in(dut_in_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
        .first_err_idx(first_s), .dbg_state(dbg_s)
    );

    always #5 clk = ~clk;

    function automatic logic gate_fn(input int mode, input logic d);
        case (mode)
            0:       return ~d;
            1:       return 1'b0;
            2:       return 1'b1;
            default: return d;
        endcase
    endfunction

    always_comb dut_out = gate_fn(gate_mode, dut_in);

    // Reference: an inverter is expected, so vector i fails when gate(p[i]) != ~p[i].
    function automatic void model(input logic [15:0] p, input int l, input int mode,
                                  input int errmax, output int e, output int f);
        e = 0;
        f = 0;
        for (int i = 0; i < l; i++) begin
            if (gate_fn(mode, p[i]) !== ~p[i]) begin
                if (e == 0) f = i;
                e++;
            end
        end
        if (e > errmax) e = errmax;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dut_in"}, 32'(dut_in), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_err"}, 32'(err_count), 32'd0);
        check({tag, "_first"}, 32'(first_err_idx), 32'd0);
    endtask

    // One complete run on the main instance with a single-cycle start.
    task automatic do_run(input logic [15:0] p, input logic [4:0] l, input int mode);
        int          eff, exp_done, exp_err, exp_first, got_done;
        logic [15:0] seen_in;
        logic [16:0] m;
        eff = (l > 5'd16) ? 16 : int'(l);
        model(p, eff, mode, 31, exp_err, exp_first);
        exp_done = eff * (S + 2) + 1;
        m = (17'd1 << eff) - 17'd1;
        gate_mode = mode;
        pattern = p;
        len = l;
        start = 1'b1;
        got_done = 0;
        seen_in = '0;
        for (int c = 1; c <= exp_done + 20 && got_done == 0; c++) begin
            step();
            start = 1'b0;
            if (done) got_done = c;
            check("busy", 32'(busy), 32'(c < exp_done));
            if (eff > 0 && c % (S + 2) == 0 && c / (S + 2) <= eff)
                seen_in[c / (S + 2) - 1] = dut_in;
            if (eff == 0) check("dut_in_empty", 32'(dut_in), 32'd0);
        end
        check("done_cycle", 32'(got_done), 32'(exp_done));
        check("dut_in_seq", 32'(seen_in), 32'(p & m[15:0]));
        step();
        check("done_one_cycle", 32'(done), 32'd0);
        check("err_count", 32'(err_count), 32'(exp_err));
        check("first_err_idx", 32'(first_err_idx), 32'(exp_first));
        check("pass", 32'(pass), 32'(exp_err == 0));
        check("dut_in_after", 32'(dut_in), 32'd0);
    endtask

    // One run of eight vectors on the 2-bit-counter instance with a stuck output.
    task automatic sat_run(input logic [15:0] p, input logic stuck);
        int exp_err, exp_first, got_done;
        model(p, 8, stuck ? 2 : 1, 3, exp_err, exp_first);
        pattern_s = p;
        len_s = 5'd8;
        dut_out_s = stuck;
        start_s = 1'b1;
        got_done = 0;
        for (int c = 1; c <= 8 * (S + 2) + 20 && got_done == 0; c++) begin
            step();
            start_s = 1'b0;
            if (done_s) got_done = c;
        end
        check("sat_done_cycle", 32'(got_done), 32'(8 * (S + 2) + 1));
        step();
        check("sat_err", 32'(err_s), 32'(exp_err));
        check("sat_first", 32'(first_s), 32'(exp_first));
        check("sat_pass", 32'(pass_s), 32'(exp_err == 0));
    endtask

    initial begin
        int e, f, n_done;
        int done_at[$];

        // Reset
        repeat (3) step();
        check_reset_values("reset");
        rst_n = 1'b1;
        step();

        // Directed runs: clean inverter, stuck-at-0, empty run
        do_run(16'hA5A5, 5'd16, 0);
        do_run(16'h00FF, 5'd16, 1);
        do_run(16'h1234, 5'd0, 0);

        // Abort at cycle 10 of a stuck-at-0 run
        gate_mode = 1;
        pattern = 16'hA5A5;
        len = 5'd16;
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            start = 1'b0;
        end
        model(16'hA5A5, 2, 1, 31, e, f);
        check("abort_pre_err", 32'(err_count), 32'(e));
        check("abort_pre_first", 32'(first_err_idx), 32'(f));
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_reset_values("abort");
        n_done = 0;
        for (int c = 0; c < 80; c++) begin
            step();
            if (done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);

        // Reset at cycle 20 of a run, with start held during reset
        do_run(16'h0F0F, 5'd16, 0);
        gate_mode = 1;
        pattern = 16'hA5A5;
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            start = 1'b0;
        end
        rst_n = 1'b0;
        start = 1'b1;
        step();
        check_reset_values("midrun_reset");
        step();
        check("reset_start_ignored", 32'(busy), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        step();
        check("reset_released_idle", 32'(busy), 32'd0);
        check("reset_released_done", 32'(done), 32'd0);

        // start held high: one run, then a second begins the cycle after done
        gate_mode = 0;
        pattern = 16'hA5A5;
        len = 5'd16;
        start = 1'b1;
        for (int c = 1; c <= 160; c++) begin
            step();
            if (c == 70) start = 1'b0;
            if (done) done_at.push_back(c);
        end
        check("held_done_count", 32'(done_at.size()), 32'd2);
        if (done_at.size() >= 1) check("held_done_first", 32'(done_at[0]), 32'd65);
        if (done_at.size() >= 2) check("held_done_second", 32'(done_at[1]), 32'd131);
        check("held_pass", 32'(pass), 32'd1);
        check("held_err", 32'(err_count), 32'd0);

        // Random runs, including len values that clamp to 16
        for (int r = 0; r < 10; r++) begin
            do_run(16'($urandom), 5'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
        end

        // Saturation of a 2-bit counter
        sat_run(16'h0000, 1'b0);
        for (int r = 0; r < 4; r++) begin
            sat_run(16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
